// File: rtl/req_ack_initiator.sv
// rtl/req_ack_initiator.sv - issues a burst of single-cycle REQ pulses and checks each ACK lands exactly LATENCY cycles later
// Tallies on-time and failed acknowledges, and flags spurious ones with a sticky err bit.
module req_ack_initiator #(
  parameter int LATENCY = 1,
  parameter int GAP     = 1,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             clr,
  output logic             REQ,
  input  logic             ACK,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err
);

  localparam int TW = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_FIN
  } state_t;

  state_t           state;
  state_t           after_gap;
  state_t           after_wait;
  logic [CNT_W-1:0] remaining;
  logic [TW-1:0]    wcnt;
  logic [TW-1:0]    gcnt;
  logic             last_k;
  logic             pass_hit;
  logic             fail_hit;
  logic             spur;

  // wcnt counts down from LATENCY, so wcnt==1 marks the expected ACK cycle
  always_comb begin
    last_k     = (wcnt == TW'(1));
    pass_hit   = (state == S_WAIT) && last_k && ACK;
    fail_hit   = (state == S_WAIT) && (last_k ? !ACK : ACK);
    spur       = ACK && ((state == S_IDLE) || (state == S_GAP) || (state == S_FIN));
    after_gap  = (remaining != '0) ? S_ISSUE : S_FIN;
    after_wait = (GAP > 0) ? S_GAP : after_gap;
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state     <= S_IDLE;
      REQ       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      wcnt      <= '0;
      gcnt      <= '0;
    end else begin
      REQ  <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= count;
            busy      <= 1'b1;
            if (count != '0) begin
              state <= S_ISSUE;
              REQ   <= 1'b1;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_ISSUE: begin
          state     <= S_WAIT;
          wcnt      <= TW'(LATENCY);
          remaining <= remaining - 1'b1;
        end
        S_WAIT: begin
          // an early ACK ends the check at once, same as the on-time slot
          if (last_k || ACK) begin
            state <= after_wait;
            REQ   <= (after_wait == S_ISSUE);
            gcnt  <= TW'(GAP);
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt <= TW'(1)) begin
            state <= after_gap;
            REQ   <= (after_gap == S_ISSUE);
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // clr wins over a same-cycle increment; counters stick at all-ones
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
    end else if (clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (pass_hit && (pass_cnt != CNT_MAX)) pass_cnt <= pass_cnt + 1'b1;
      if (fail_hit && (fail_cnt != CNT_MAX)) fail_cnt <= fail_cnt + 1'b1;
      if (fail_hit || spur) err <= 1'b1;
    end
  end

endmodule

// File: doc/req_ack_initiator.md
Name: req_ack_initiator

Overview:
Initiator side of the single-bit request/acknowledge protocol. In that protocol a responder registers REQ and returns it as ACK a fixed number of cycles later; the reference responder returns it one cycle later. This block issues a programmed burst of single-cycle requests and checks that each ACK arrives in exactly the expected cycle. It counts passes and failures and flags spurious acknowledges. It sits in the test/bring-up harness opposite the responder, and gives a synthesizable equivalent of the "REQ |-> ##LATENCY ACK" property.

Parameters:
LATENCY, 1, cycles from the REQ cycle to the expected ACK cycle; legal range 1..15.
GAP, 1, idle cycles after each check before the next REQ; legal range 0..15.
CNT_W, 8, width of the burst length input and of the result counters.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
ASYNCRESETN  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse that launches a burst; sampled only in IDLE.
count  input  CNT_W  number of requests in the burst; latched on the accepted start.
clr  input  1  synchronous clear of pass_cnt, fail_cnt and err.
REQ  output  1  request to the responder; one-cycle pulse per request.
ACK  input  1  acknowledge from the responder.
busy  output  1  high whenever the state is not IDLE.
done  output  1  one-cycle pulse when a burst completes.
pass_cnt  output  CNT_W  saturating count of on-time ACKs.
fail_cnt  output  CNT_W  saturating count of early or missing ACKs.
err  output  1  sticky flag; set on any failure or spurious ACK.

Behaviour:
- Reset, asserted asynchronously:
  - State goes to IDLE.
  - REQ, busy, done, err = 0; pass_cnt = fail_cnt = 0.
  - REQ drops immediately, not at the next edge.
  - Reset mid-burst abandons the burst; no done pulse is produced.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, GAP, FIN.
- IDLE:
  - start=1 with count≠0: latch remaining=count, go to ISSUE.
  - start=1 with count=0: go to FIN; no REQ is issued.
  - Otherwise stay in IDLE.
- ISSUE:
  - REQ=1 for exactly this cycle (call it k=0).
  - Load the wait counter with LATENCY, decrement remaining, go to WAIT.
- WAIT covers cycles k=1..LATENCY:
  - ACK=1 at k<LATENCY: early failure. fail_cnt+1, err=1, leave WAIT immediately.
  - At k=LATENCY, ACK=1: pass_cnt+1.
  - At k=LATENCY, ACK=0: fail_cnt+1, err=1.
  - Leaving WAIT: go to GAP if GAP>0; otherwise go to ISSUE if remaining≠0, else FIN.
- GAP:
  - Lasts GAP cycles.
  - ACK=1 in GAP is spurious: err=1, counters unchanged.
  - Exit to ISSUE if remaining≠0, else FIN.
- FIN: done=1 for one cycle, then IDLE.
- ACK=1 while in IDLE or FIN is spurious: err=1.
- With a 1-cycle responder, LATENCY=1, GAP=0: REQ toggles every 2 cycles.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Counters and err accumulate across bursts until clr or reset.
- clr has priority over a same-cycle increment: the result is 0.
- start while busy is ignored; count is not re-latched.

Test Plan:
1. LATENCY=1, GAP=0, ACK driven by a 1-cycle FF of REQ; start with count=3 -> REQ high on cycles 1,3,5; done on cycle 8; pass_cnt=3, fail_cnt=0, err=0.
2. Same config, ACK tied 0, count=4 -> fail_cnt=4, err=1, done pulses once, busy low after done.
3. LATENCY=2, ACK=REQ delayed by 1 cycle, count=2 -> each request fails early at k=1; fail_cnt=2, pass_cnt=0.
4. GAP=2, responder also pulses ACK during each GAP, count=2 -> pass_cnt=2, err=1, fail_cnt=0.
5. count=5; deassert ASYNCRESETN mid-way between two clock edges in WAIT of the 3rd request -> REQ/busy/counters 0 before the next edge, no done; after release, count=1 burst gives pass_cnt=1.
6. CNT_W=2; run three bursts of count=3 with ACK tied 0 -> fail_cnt saturates at 3; clr with a same-cycle failure -> fail_cnt=0, err=0; count=0 start -> done next-but-one cycle, no REQ.
